// File: rtl/stream_demux_pkg.sv
// Shared constants, width helpers and default array types for the stream demux slice.
//   sel_width(n) : select width for n channels (at least 1 bit)
//   cnt_width(d) : occupancy width able to hold 0..d
package stream_demux_pkg;

  localparam int unsigned NUM_ELEM_DEF   = 6;
  localparam int unsigned ELEM_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 4;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  localparam int unsigned SEL_W_DEF = sel_width(NUM_ELEM_DEF);
  localparam int unsigned CNT_W_DEF = cnt_width(DEPTH_DEF);

  // Per-channel payload and occupancy arrays at the default configuration.
  typedef logic [NUM_ELEM_DEF-1:0][ELEM_WIDTH_DEF-1:0] data_arr_t;
  typedef logic [NUM_ELEM_DEF-1:0][CNT_W_DEF-1:0]      cnt_arr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head data is visible while not empty.
//   clk_i, arst_ni     : clock, async active-low reset (flushes pointers)
//   push_i, data_i     : write a word (ignored when full)
//   pop_i, data_o      : consume the head word (ignored when empty)
//   full_o, empty_o    : status from registered pointers only
//   count_o            : occupancy 0..DEPTH
module sync_fifo
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    fill;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign fill    = wr_ptr - rd_ptr;
  assign full_o  = (fill == PW'(DEPTH));
  assign empty_o = (wr_ptr == rd_ptr);
  assign count_o = CW'(fill);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  // Pointer state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only observed between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/stream_demux.sv
// Flow-controlled 1-to-NUM_ELEM stream demultiplexer with per-channel FIFOs.
//   clk_i, arst_ni            : clock, async active-low reset
//   s_i, bcast_i              : channel select / broadcast-to-all for the input beat
//   i_i, i_valid_i, i_ready_o : input stream (ready depends on full flags and select only)
//   o_o, o_valid_o, o_ready_i : per-channel output streams (data zeroed when not valid)
//   count_o                   : per-channel occupancy
//   drop_o                    : pulses the cycle after an out-of-range beat was discarded
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned NUM_ELEM   = NUM_ELEM_DEF,
  parameter int unsigned ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                                         clk_i,
  input  logic                                         arst_ni,
  input  logic [sel_width(NUM_ELEM)-1:0]               s_i,
  input  logic                                         bcast_i,
  input  logic [ELEM_WIDTH-1:0]                        i_i,
  input  logic                                         i_valid_i,
  output logic                                         i_ready_o,
  output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]          o_o,
  output logic [NUM_ELEM-1:0]                          o_valid_o,
  input  logic [NUM_ELEM-1:0]                          o_ready_i,
  output logic [NUM_ELEM-1:0][cnt_width(DEPTH)-1:0]    count_o,
  output logic                                         drop_o
);

  localparam int unsigned SEL_W = sel_width(NUM_ELEM);

  logic [NUM_ELEM-1:0]                 full;
  logic [NUM_ELEM-1:0]                 empty;
  logic [NUM_ELEM-1:0]                 sel_hit;
  logic [NUM_ELEM-1:0]                 push;
  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] head;
  logic                                in_range;
  logic                                accept;
  logic                                drop_q;

  // One-hot select decode; all-zero when s_i names no channel.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      sel_hit[k] = (s_i == SEL_W'(k));
    end
  end

  assign in_range = |sel_hit;

  // Broadcast is all-or-nothing; out-of-range beats are always taken and dropped.
  always_comb begin
    i_ready_o = 1'b1;
    if (bcast_i)       i_ready_o = ~|full;
    else if (in_range) i_ready_o = ~|(full & sel_hit);
  end

  assign accept = i_valid_i & i_ready_o;

  always_comb begin
    push = '0;
    if (accept) push = bcast_i ? {NUM_ELEM{1'b1}} : sel_hit;
  end

  // Discard indication, registered so it appears the cycle after acceptance.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) drop_q <= 1'b0;
    else          drop_q <= accept & ~bcast_i & ~in_range;
  end

  assign drop_o = drop_q;

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_chan
    sync_fifo #(
      .WIDTH (ELEM_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .push_i  (push[g]),
      .data_i  (i_i),
      .pop_i   (o_ready_i[g]),
      .data_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .count_o (count_o[g])
    );

    assign o_valid_o[g] = ~empty[g];
    // Stale storage never leaks onto an idle channel.
    assign o_o[g]       = empty[g] ? '0 : head[g];
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered, flow-controlled successor to the combinational demux.
- Routes one input stream to one of NUM_ELEM output streams using valid/ready handshakes.
- Each output has its own FIFO buffer, so a stalled output does not block traffic to the other outputs.
- Adds broadcast mode, out-of-range select handling and per-channel occupancy reporting. Sits between a single producer and multiple independent consumers.

Parameters:
- NUM_ELEM, 6, number of output channels (>=2).
- ELEM_WIDTH, 8, data width per element.
- DEPTH, 4, per-channel FIFO depth (power of 2, >=2).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- s_i  in  $clog2(NUM_ELEM)  channel select, sampled with the input beat.
- bcast_i  in  1  broadcast: write beat to all channels; s_i ignored.
- i_i  in  ELEM_WIDTH  input data.
- i_valid_i  in  1  input beat valid.
- i_ready_o  out  1  input beat accepted when i_valid_i & i_ready_o.
- o_o  out  [NUM_ELEM][ELEM_WIDTH]  per-channel head data.
- o_valid_o  out  NUM_ELEM  per-channel head valid (FIFO not empty).
- o_ready_i  in  NUM_ELEM  per-channel consumer ready.
- count_o  out  [NUM_ELEM][$clog2(DEPTH+1)]  per-channel occupancy.
- drop_o  out  1  one-cycle pulse: a beat with out-of-range s_i was accepted and discarded.

Behaviour:
- Reset (arst_ni=0, asynchronous):
  - All FIFOs flushed; pointers and counts go to 0.
  - o_valid_o=0, count_o=0, drop_o=0, o_o=0.
  - Reset mid-operation discards all buffered beats; no partial beat survives.
- o_o[k] is forced to 0 whenever o_valid_o[k]=0.
- Push: occurs at the posedge where i_valid_i & i_ready_o.
  - Normal mode: writes into channel s_i.
  - Broadcast mode: writes into every channel.
- i_ready_o is a registered-state function only (full flags, s_i, bcast_i). There is no combinational path from o_ready_i.
  - Normal, s_i < NUM_ELEM: i_ready_o = !full[s_i].
  - Normal, s_i >= NUM_ELEM: i_ready_o = 1. The beat is accepted, discarded, and drop_o pulses high in the following cycle.
  - Broadcast: i_ready_o = AND of !full[k] over all k. The beat is all-or-nothing; no partial broadcast.
- Pop: channel k pops at the posedge where o_valid_o[k] & o_ready_i[k]. Channels pop independently in the same cycle.
- Latency: a beat pushed at edge N appears on o_valid_o/o_o from edge N onward (visible in cycle N+1). There is no fall-through path.
- Ordering: each channel is FIFO-ordered; beats within a channel never reorder.
- Full with simultaneous pop: a push to a full channel is refused even if that channel pops in the same cycle (ready depends on full only). Count goes DEPTH to DEPTH-1.
- Empty: pop is impossible; a push to an empty channel sets count=1 and valid=1 next cycle.
- Simultaneous push and pop on one non-full, non-empty channel: count is unchanged and data order is preserved.
- Pointer wrap: read/write pointers wrap modulo DEPTH. count_o is computed from extra-MSB pointers, range 0..DEPTH.
- i_valid_i low: no state change from the input side. s_i and bcast_i are don't-care.
- Input stability is not required. Each cycle is evaluated independently (the protocol does not require holding a refused beat).

Decomposition:
- Package stream_demux_pkg:
  - sel-width and count-width helper constants derived from NUM_ELEM and DEPTH.
  - typedef for the per-channel data array.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk_i, arst_ni, push, data in, pop, data out, full, empty, count).
  - Instantiated NUM_ELEM times via generate.
  - Top level holds select decode, broadcast AND, drop-pulse register and output masking.

Test Plan:
- Reset then idle:
  - Apply arst_ni low 100ns and release -> o_valid_o=0, count_o all 0, i_ready_o=1 for s_i=0, drop_o=0.
  - Assert arst_ni mid-traffic with 3 beats queued -> all counts 0 on the same cycle.
- Routing and latency:
  - s_i=2, i_i=8'hA5, valid for one cycle, o_ready_i=0 -> next cycle o_valid_o=6'b000100, o_o[2]=8'hA5, count_o[2]=1, all other o_o=0.
- Backpressure and full:
  - DEPTH=4, o_ready_i[1]=0, push 5 beats 8'h01..8'h05 to s_i=1 -> i_ready_o drops after the 4th beat and count_o[1]=4.
  - Meanwhile a push to s_i=3 is still accepted.
  - Release o_ready_i[1] -> pops yield 01,02,03,04 in order. The 5th beat, re-driven, is accepted once count_o[1]<4.
- Broadcast:
  - Fill channel 0 to 4 beats, then bcast_i=1, i_i=8'h3C -> i_ready_o=0 and no channel count changes.
  - Pop one beat from channel 0 -> broadcast accepted; every channel receives 8'h3C.
- Out-of-range select:
  - NUM_ELEM=6, s_i=7, i_i=8'hFF, valid -> i_ready_o=1, drop_o pulses one cycle later, no count changes.
- Random soak:
  - 1000 cycles of random s_i/bcast_i/i_i/o_ready_i against a per-channel reference queue model.
  - Zero mismatches; pass/fail tallied with result_print.
